// File: rtl/formatter_pkt_if.sv
// Packet formatter bus: upstream word handshake plus downstream grant/data.
// The master side drives words and grants; the formatter sits on the slave side.
interface formatter_pkt_if #(
  parameter int DW    = 32,
  parameter int ID_W  = 2,
  parameter int LEN_W = 6
);
  logic             a2f_val;
  logic [ID_W-1:0]  a2f_id;
  logic [LEN_W-1:0] a2f_len;
  logic [DW-1:0]    a2f_data;
  logic             a2f_ack;
  logic             fmt_id_req;
  logic             fmt_req;
  logic             fmt_grant;
  logic             fmt_start;
  logic             fmt_end;
  logic [DW-1:0]    fmt_data;
  logic [ID_W-1:0]  fmt_chid;
  logic [LEN_W-1:0] fmt_length;

  modport master (
    output a2f_val, a2f_id, a2f_len, a2f_data, fmt_grant,
    input  a2f_ack, fmt_id_req, fmt_req, fmt_start, fmt_end,
           fmt_data, fmt_chid, fmt_length
  );

  modport slave (
    input  a2f_val, a2f_id, a2f_len, a2f_data, fmt_grant,
    output a2f_ack, fmt_id_req, fmt_req, fmt_start, fmt_end,
           fmt_data, fmt_chid, fmt_length
  );
endinterface

// File: rtl/formatter_pkt.sv
// Packet formatter: buffers one packet of up to MAXLEN words, requests a
// downstream grant, then replays the packet with start/end framing.
//
// state | meaning
// IDLE  | ready for a new packet; first word goes to slot 0, id/len latched
// LOAD  | collecting the remaining words of the packet
// REQ   | packet complete, fmt_req high until a grant is sampled
// SEND  | one buffered word per cycle on fmt_data
// GAPW  | GAP idle cycles after fmt_end before accepting the next packet
module formatter_pkt #(
  parameter int DW     = 32,
  parameter int ID_W   = 2,
  parameter int LEN_W  = 6,
  parameter int MAXLEN = 32,
  parameter int GAP    = 0
) (
  input logic            clk_i,
  input logic            rst_n,
  formatter_pkt_if.slave pkt
);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, SEND, GAPW} state_t;

  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAXLEN);
  localparam logic [LEN_W:0]   MAX_X  = (LEN_W+1)'(MAXLEN);
  localparam logic [LEN_W:0]   ONE_X  = (LEN_W+1)'(1);

  state_t           state_q;
  logic [LEN_W:0]   wr_ptr_q, rd_ptr_q;
  logic [LEN_W:0]   wr_ptr_d, rd_ptr_d;
  logic [GW-1:0]    gap_cnt_q;
  logic             fmt_id_req_q, fmt_req_q, fmt_start_q, fmt_end_q;
  logic [DW-1:0]    fmt_data_q;
  logic [ID_W-1:0]  fmt_chid_q;
  logic [LEN_W-1:0] fmt_length_q;

  logic [DW-1:0]    mem [MAXLEN];

  logic             xfer;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W:0]   len_x;
  logic [DW-1:0]    rd_word;

  // Handshake, length clamp and pointer increments
  always_comb begin
    xfer     = pkt.a2f_val && ((state_q == IDLE) || (state_q == LOAD));
    len_eff  = ((pkt.a2f_len == '0) || ({1'b0, pkt.a2f_len} > MAX_X)) ? MAX_L : pkt.a2f_len;
    len_x    = {1'b0, fmt_length_q};
    wr_ptr_d = wr_ptr_q + ONE_X;
    rd_ptr_d = rd_ptr_q + ONE_X;
    rd_word  = mem[rd_ptr_q[AW-1:0]];
  end

  // Packet buffer; contents survive reset since pointers gate all reads
  always_ff @(posedge clk_i) begin
    if (xfer) mem[wr_ptr_q[AW-1:0]] <= pkt.a2f_data;
  end

  // Sequencer with registered outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      gap_cnt_q    <= '0;
      fmt_id_req_q <= 1'b0;
      fmt_req_q    <= 1'b0;
      fmt_start_q  <= 1'b0;
      fmt_end_q    <= 1'b0;
      fmt_data_q   <= '0;
      fmt_chid_q   <= '0;
      fmt_length_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fmt_id_req_q <= 1'b1;
          if (xfer) begin
            fmt_id_req_q <= 1'b0;
            fmt_chid_q   <= pkt.a2f_id;
            fmt_length_q <= len_eff;
            wr_ptr_q     <= ONE_X;
            if (len_eff == LEN_W'(1)) begin
              state_q   <= REQ;
              fmt_req_q <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            wr_ptr_q <= wr_ptr_d;
            if (wr_ptr_d == len_x) begin
              state_q   <= REQ;
              fmt_req_q <= 1'b1;
            end
          end
        end

        REQ: begin
          if (fmt_req_q && pkt.fmt_grant) begin
            fmt_req_q   <= 1'b0;
            state_q     <= SEND;
            fmt_data_q  <= rd_word;
            fmt_start_q <= 1'b1;
            fmt_end_q   <= (rd_ptr_d == len_x);
            rd_ptr_q    <= rd_ptr_d;
          end
        end

        SEND: begin
          if (fmt_end_q) begin
            fmt_start_q <= 1'b0;
            fmt_end_q   <= 1'b0;
            if (GAP == 0) begin
              state_q      <= IDLE;
              fmt_id_req_q <= 1'b1;
              wr_ptr_q     <= '0;
              rd_ptr_q     <= '0;
            end else begin
              state_q   <= GAPW;
              gap_cnt_q <= GAP_LOAD;
            end
          end else begin
            fmt_data_q  <= rd_word;
            fmt_start_q <= 1'b0;
            fmt_end_q   <= (rd_ptr_d == len_x);
            rd_ptr_q    <= rd_ptr_d;
          end
        end

        GAPW: begin
          if (gap_cnt_q == '0) begin
            state_q      <= IDLE;
            fmt_id_req_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt.a2f_ack    = xfer;
  assign pkt.fmt_id_req = fmt_id_req_q;
  assign pkt.fmt_req    = fmt_req_q;
  assign pkt.fmt_start  = fmt_start_q;
  assign pkt.fmt_end    = fmt_end_q;
  assign pkt.fmt_data   = fmt_data_q;
  assign pkt.fmt_chid   = fmt_chid_q;
  assign pkt.fmt_length = fmt_length_q;

endmodule
